// File: rtl/robot.sv
// Wall-following trash-collecting robot controller: Moore FSM with registered
// front/turn/remove requests, a sticky wall_seen flag and a timed removal state.
`default_nettype none

module robot #(
   parameter int REMOVE_CYCLES = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic head,
   input  logic left,
   input  logic under,
   input  logic barrier,
   output logic front,
   output logic turn,
   output logic remove
);

   localparam int CNT_W = (REMOVE_CYCLES < 2) ? 1 : $clog2(REMOVE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REMOVE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FWD    = 3'd1,
      TURN_L = 3'd2,
      TR1    = 3'd3,
      TR2    = 3'd4,
      TR3    = 3'd5,
      REM    = 3'd6,
      HALT   = 3'd7
   } state_t;

   state_t           state_q, state_d;
   state_t           decision;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wall_seen_q, wall_seen_d;
   logic             front_q, front_d;
   logic             turn_q, turn_d;
   logic             remove_q, remove_d;

   // Shared navigation decision; the TURN_L exclusion prevents spinning in open space.
   always_comb begin
      decision = FWD;
      if (under)
         decision = HALT;
      else if (barrier)
         decision = REM;
      else if (head)
         decision = TR1;
      else if (!left && wall_seen_q && (state_q != TURN_L))
         decision = TURN_L;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wall_seen_d = wall_seen_q | head | left;

      case (state_q)
         IDLE, FWD, TURN_L, TR3: begin
            state_d = decision;
            if (decision == REM)
               cnt_d = '0;
         end
         TR1:  state_d = TR2;
         TR2:  state_d = TR3;
         REM: begin
            if (cnt_q == CNT_LAST) begin
               state_d = decision;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase

      front_d  = (state_d == FWD);
      turn_d   = (state_d == TURN_L) || (state_d == TR1) ||
                 (state_d == TR2)    || (state_d == TR3);
      remove_d = (state_d == REM);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wall_seen_q <= 1'b0;
         front_q     <= 1'b0;
         turn_q      <= 1'b0;
         remove_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wall_seen_q <= wall_seen_d;
         front_q     <= front_d;
         turn_q      <= turn_d;
         remove_q    <= remove_d;
      end
   end

   assign front  = front_q;
   assign turn   = turn_q;
   assign remove = remove_q;

endmodule

`default_nettype wire

// File: tb/tb_robot.sv
// Scoreboard bench for robot: expected {front,turn,remove} pushed per driven cycle,
// popped and compared one step after the following rising edge.
`default_nettype none

module tb_robot;

   logic clock;
   logic reset;
   logic head, left, under, barrier;
   logic front, turn, remove;

   int checks = 0;
   int errors = 0;

   logic [2:0] sb[$];

   robot #(.REMOVE_CYCLES(3)) dut (
      .clock   (clock),
      .reset   (reset),
      .head    (head),
      .left    (left),
      .under   (under),
      .barrier (barrier),
      .front   (front),
      .turn    (turn),
      .remove  (remove)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Inputs packed as {head, left, under, barrier}; expected as {front, turn, remove}.
   task automatic apply(input logic [3:0] stim, input logic [2:0] expv);
      {head, left, under, barrier} = stim;
      sb.push_back(expv);
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b0;
      {head, left, under, barrier} = 4'b0000;
      @(posedge clock);
      #1;
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      logic [2:0] got;
      reset = 1'b1;
      {head, left, under, barrier} = 4'b0000;
      #2;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 0) #1;
         else begin
            @(posedge clock);
            #1;
         end
         got = {front, turn, remove};
         checks++;
         if (got !== 3'b000) begin
            errors++;
            $display("FAIL reset[%0d]: got f/t/r=%b want 000", i, got);
         end
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_forward();
      logic [2:0] got, want;
      logic [3:0] stim [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      logic [2:0] expv [5] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
      for (int i = 0; i < 5; i++) begin
         apply(stim[i], expv[i]);
         got  = {front, turn, remove};
         want = sb.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL forward[%0d]: got f/t/r=%b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_wall_turn();
      logic [2:0] got, want;
      logic [3:0] stim [5] = '{4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
      logic [2:0] expv [5] = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b100};
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         apply(stim[i], expv[i]);
         got  = {front, turn, remove};
         want = sb.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL wall_turn[%0d]: got f/t/r=%b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_barrier();
      logic [2:0] got, want;
      logic [3:0] stim [9] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
                               4'b0001, 4'b0001, 4'b1010, 4'b0100};
      logic [2:0] expv [9] = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b100,
                               3'b001, 3'b001, 3'b001, 3'b100};
      pulse_reset();
      for (int i = 0; i < 9; i++) begin
         apply(stim[i], expv[i]);
         got  = {front, turn, remove};
         want = sb.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL barrier[%0d]: got f/t/r=%b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_alternate();
      logic [2:0] got, want;
      logic [3:0] stim [6] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      logic [2:0] expv [6] = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
      pulse_reset();
      for (int i = 0; i < 6; i++) begin
         apply(stim[i], expv[i]);
         got  = {front, turn, remove};
         want = sb.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL alternate[%0d]: got f/t/r=%b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_priority_halt();
      logic [2:0] got, want;
      logic [3:0] stim [8] = '{4'b1001, 4'b0000, 4'b0000, 4'b1011,
                               4'b0001, 4'b1000, 4'b0000, 4'b0100};
      logic [2:0] expv [8] = '{3'b001, 3'b001, 3'b001, 3'b000,
                               3'b000, 3'b000, 3'b000, 3'b000};
      pulse_reset();
      for (int i = 0; i < 8; i++) begin
         apply(stim[i], expv[i]);
         got  = {front, turn, remove};
         want = sb.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL priority_halt[%0d]: got f/t/r=%b want %b", i, got, want);
         end
      end
      pulse_reset();
      apply(4'b0000, 3'b100);
      got  = {front, turn, remove};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL halt_exit: got f/t/r=%b want %b", got, want);
      end
   endtask

   task automatic test_reset_mid_rem();
      logic [2:0] got, want;
      logic [3:0] stim [2] = '{4'b0001, 4'b0000};
      logic [2:0] expv [2] = '{3'b001, 3'b001};
      pulse_reset();
      for (int i = 0; i < 2; i++) begin
         apply(stim[i], expv[i]);
         got  = {front, turn, remove};
         want = sb.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL mid_rem[%0d]: got f/t/r=%b want %b", i, got, want);
         end
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      got = {front, turn, remove};
      checks++;
      if (got !== 3'b000) begin
         errors++;
         $display("FAIL mid_rem_async: got f/t/r=%b want 000", got);
      end
      reset = 1'b1;
      apply(4'b0000, 3'b100);
      got  = {front, turn, remove};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL mid_rem_release: got f/t/r=%b want %b", got, want);
      end
      apply(4'b0000, 3'b100);
      got  = {front, turn, remove};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL mid_rem_after: got f/t/r=%b want %b", got, want);
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_wall_turn();
      test_barrier();
      test_alternate();
      test_priority_halt();
      test_reset_mid_rem();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
